adder_display_ctrl: RTL and testbench

Sequencer for the 4-bit adder/BCD display path. Captures two 4-bit operands from switches on successive enter pulses, registers the 5-bit sum, and splits the sum (0..30) into tens/ones BCD digits. Time-multiplexes the two digits onto a shared seven-segment decoder input through a scan counter. Sits between the debounced board inputs and the display decoder.

---
 rtl/adder_display_ctrl_pkg.sv | 15 +
 rtl/adder_display_ctrl_bin5_to_bcd2.sv | 27 ++
 rtl/adder_display_ctrl.sv | 106 ++++++++++
 tb/tb_adder_display_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/adder_display_ctrl_pkg.sv
// Shared encodings for the adder/BCD display path.
// State codes, blank digit value and default scan divider.
package adder_display_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GOT_A = 3'd1,
    ST_ADD   = 3'd2,
    ST_SHOW  = 3'd3
  } state_t;

  localparam logic [3:0] BLANK = 4'hF;
  localparam int SCAN_DIV_DEF = 50000;

endpackage

// File: rtl/adder_display_ctrl_bin5_to_bcd2.sv
// 5-bit binary to two BCD digits (0..31).
// Pure combinational range split.
module bin5_to_bcd2 (
  input  logic [4:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  always_comb begin
    tens = 4'd0;
    ones = 4'd0;
    if (bin >= 5'd30) begin
      tens = 4'd3;
      ones = 4'(bin - 5'd30);
    end else if (bin >= 5'd20) begin
      tens = 4'd2;
      ones = 4'(bin - 5'd20);
    end else if (bin >= 5'd10) begin
      tens = 4'd1;
      ones = 4'(bin - 5'd10);
    end else begin
      tens = 4'd0;
      ones = bin[3:0];
    end
  end

endmodule

// File: rtl/adder_display_ctrl.sv
// Operand capture, add sequencer and two-digit
// multiplexed BCD display driver.
module adder_display_ctrl
  import adder_display_ctrl_pkg::*;
#(
  parameter int SCAN_DIV = SCAN_DIV_DEF,
  parameter int SCAN_W   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sw,
  input  logic       enter,
  input  logic       clear,
  output logic [2:0] state,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  output logic [4:0] result,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       valid,
  output logic [1:0] an,
  output logic [3:0] digit
);

  state_t            st;
  logic [SCAN_W-1:0] cnt;
  logic              idx;

  assign state = st;

  always_ff @(posedge clk) begin
    if (reset) begin
      st     <= ST_IDLE;
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
      valid  <= 1'b0;
    end else if (clear) begin
      st     <= ST_IDLE;
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
      valid  <= 1'b0;
    end else begin
      unique case (st)
        ST_IDLE: begin
          if (enter) begin
            op_a <= sw;
            st   <= ST_GOT_A;
          end
        end
        ST_GOT_A: begin
          if (enter) begin
            op_b <= sw;
            st   <= ST_ADD;
          end
        end
        ST_ADD: begin
          result <= {1'b0, op_a} + {1'b0, op_b};
          valid  <= 1'b1;
          st     <= ST_SHOW;
        end
        ST_SHOW: begin
          if (enter) begin
            op_a  <= sw;
            valid <= 1'b0;
            st    <= ST_GOT_A;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  // Scan free-runs regardless of FSM state and clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      idx <= 1'b0;
      an  <= 2'b10;
    end else if (cnt == SCAN_W'(SCAN_DIV - 1)) begin
      cnt <= '0;
      idx <= ~idx;
      an  <= idx ? 2'b10 : 2'b01;
    end else begin
      cnt <= cnt + SCAN_W'(1);
    end
  end

  bin5_to_bcd2 u_bcd (
    .bin  (result),
    .tens (tens),
    .ones (ones)
  );

  always_comb begin
    digit = BLANK;
    if (valid) begin
      if (!idx)
        digit = ones;
      else if (tens != 4'd0)
        digit = tens;
    end
  end

endmodule

// File: tb/tb_adder_display_ctrl.sv
// Self-checking bench for adder_display_ctrl with
// a reference model and vector table.
module tb_adder_display_ctrl;

  localparam int SD = 4;

  logic       clk;
  logic       reset;
  logic [3:0] sw;
  logic       enter;
  logic       clear;
  logic [2:0] state;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic [4:0] result;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       valid;
  logic [1:0] an;
  logic [3:0] digit;

  adder_display_ctrl #(
    .SCAN_DIV (SD),
    .SCAN_W   (16)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .sw     (sw),
    .enter  (enter),
    .clear  (clear),
    .state  (state),
    .op_a   (op_a),
    .op_b   (op_b),
    .result (result),
    .tens   (tens),
    .ones   (ones),
    .valid  (valid),
    .an     (an),
    .digit  (digit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int m_st, m_a, m_b, m_res, m_v, m_t;

  typedef struct {
    int a;
    int b;
    int res;
    int t;
    int o;
    int dt;
    int d_o;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Model advances on every edge from the applied inputs.
  task automatic model_step();
    if (reset) begin
      m_st = 0; m_a = 0; m_b = 0;
      m_res = 0; m_v = 0; m_t = 0;
    end else begin
      m_t++;
      if (clear) begin
        m_st = 0; m_a = 0; m_b = 0;
        m_res = 0; m_v = 0;
      end else begin
        case (m_st)
          0: if (enter) begin m_a = sw; m_st = 1; end
          1: if (enter) begin m_b = sw; m_st = 2; end
          2: begin
            m_res = m_a + m_b; m_v = 1; m_st = 3;
          end
          3: if (enter) begin
            m_a = sw; m_v = 0; m_st = 1;
          end
          default: m_st = 0;
        endcase
      end
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all();
    int slot, e_an, e_dig;
    slot  = (m_t / SD) % 2;
    e_an  = slot ? 2'b01 : 2'b10;
    if (!m_v)
      e_dig = 15;
    else if (slot == 0)
      e_dig = m_res % 10;
    else
      e_dig = (m_res / 10 == 0) ? 15 : m_res / 10;
    chk("state", state, m_st);
    chk("op_a", op_a, m_a);
    chk("op_b", op_b, m_b);
    chk("result", result, m_res);
    chk("valid", valid, m_v);
    chk("tens", tens, m_res / 10);
    chk("ones", ones, m_res % 10);
    chk("an", an, e_an);
    chk("digit", digit, e_dig);
  endtask

  task automatic press(input int v);
    sw = 4'(v); enter = 1'b1;
    cyc();
    enter = 1'b0;
    check_all();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    check_all();
  endtask

  initial begin
    vecs[0] = '{7, 9, 16, 1, 6, 1, 6};
    vecs[1] = '{15, 15, 30, 3, 0, 3, 0};
    vecs[2] = '{0, 0, 0, 0, 0, 15, 0};
    vecs[3] = '{9, 1, 10, 1, 0, 1, 0};
    vecs[4] = '{5, 4, 9, 0, 9, 15, 9};
    vecs[5] = '{15, 0, 15, 1, 5, 1, 5};

    reset = 1'b1; sw = '0; enter = 1'b0; clear = 1'b0;
    cyc(); cyc();
    check_all();
    chk("rst_an", an, 2'b10);
    chk("rst_digit", digit, 15);
    reset = 1'b0;

    // Table-driven add vectors
    foreach (vecs[i]) begin
      do_clear();
      press(vecs[i].a);
      press(vecs[i].b);
      cyc();
      check_all();
      chk("v_result", result, vecs[i].res);
      chk("v_tens", tens, vecs[i].t);
      chk("v_ones", ones, vecs[i].o);
      chk("v_valid", valid, 1);
      chk("v_state", state, 3);
      for (int k = 0; k < 2 * SD; k++) begin
        cyc();
        check_all();
        if (an == 2'b10)
          chk("v_dig_ones", digit, vecs[i].d_o);
        else
          chk("v_dig_tens", digit, vecs[i].dt);
      end
    end

    // enter during ADD is dropped, then chained entry
    do_clear();
    press(3);
    press(5);
    press(12);
    chk("add_ign_state", state, 3);
    chk("add_ign_op_b", op_b, 5);
    chk("add_ign_res", result, 8);
    press(4);
    chk("chain_op_a", op_a, 4);
    chk("chain_valid", valid, 0);
    chk("chain_state", state, 1);
    chk("chain_res", result, 8);

    // clear beats enter in GOT_A
    do_clear();
    press(6);
    sw = 4'd9; enter = 1'b1; clear = 1'b1;
    cyc();
    enter = 1'b0; clear = 1'b0;
    check_all();
    chk("clr_state", state, 0);
    chk("clr_op_a", op_a, 0);
    chk("clr_op_b", op_b, 0);
    chk("clr_valid", valid, 0);

    // reset mid-scan in SHOW
    press(8);
    press(8);
    cyc(); check_all();
    cyc(); check_all();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check_all();
    chk("mrst_state", state, 0);
    chk("mrst_res", result, 0);
    chk("mrst_an", an, 2'b10);
    chk("mrst_digit", digit, 15);
    for (int k = 0; k < SD + 2; k++) begin
      cyc();
      check_all();
    end

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      sw    = 4'($urandom_range(0, 15));
      enter = ($urandom_range(0, 2) == 0);
      clear = ($urandom_range(0, 19) == 0);
      reset = ($urandom_range(0, 99) == 0);
      cyc();
      check_all();
    end
    reset = 1'b0; enter = 1'b0; clear = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
